pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/step/abort control for a 5-stage pipeline.
// It holds the pipeline frozen while idle. It runs or single-steps it on command.
// It drains the pipeline for DRAIN_CYCLES after a HALT instruction reaches decode.
// It also produces the load-use stall, PC enable and IF/ID flush controls.
// Optional feature: define HAZARD_DETECT_EN to enable load-use hazard detection;
// without it the stall request is tied low.
//
// Handshake: a command is accepted on a rising edge where i_cmd_valid and
// o_cmd_ready are both 1. o_cmd_ready depends only on the current state, never
// on i_cmd_valid. Commands presented while o_cmd_ready=0 are not consumed.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CNT       = 32
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_stop,
    input  logic [4:0]        i_id_rs,
    input  logic [4:0]        i_id_rt,
    input  logic              i_ex_memRead,
    input  logic [4:0]        i_ex_rt,
    input  logic              i_jump,
    output logic              o_halt,
    output logic              o_stall,
    output logic              o_pc_en,
    output logic              o_flush_if,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_state,
    output logic [NB_CNT-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    // Drain counter only has to reach DRAIN_CYCLES-1.
    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   drain_cnt;
    logic            drain_last;
    logic            cmd_acc;
    logic            abort_acc;
    logic            hz;

    assign cmd_acc    = i_cmd_valid && o_cmd_ready;
    assign abort_acc  = cmd_acc && (i_cmd == CMD_ABORT);
    assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign o_state    = state;

`ifdef HAZARD_DETECT_EN
    // Load in EX writing a register that the instruction in ID reads; r0 never hazards.
    assign hz = i_ex_memRead && (i_ex_rt != 5'd0) &&
                ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{i_ex_memRead, i_ex_rt, i_id_rs, i_id_rt};
    assign hz = 1'b0;
`endif

    // State register; reset parks the sequencer in IDLE immediately.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In RUN, an accepted abort beats a simultaneous HALT.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_acc && (i_cmd == CMD_RUN)) begin
                    state_next = S_RUN;
                end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
                    state_next = S_STEP;
                end
            end
            S_RUN: begin
                if (abort_acc) begin
                    state_next = S_IDLE;
                end else if (i_stop) begin
                    state_next = S_DRAIN;
                end
            end
            S_STEP: begin
                state_next = i_stop ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (abort_acc) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs: readiness, freeze and status flags.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_halt      = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                o_halt      = 1'b1;
            end
            S_RUN: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b1;
            end
            S_STEP: begin
                o_busy = 1'b1;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
            end
            S_DONE: begin
                o_cmd_ready = 1'b1;
                o_halt      = 1'b1;
                o_done      = 1'b1;
            end
            default: begin
                o_cmd_ready = 1'b1;
                o_halt      = 1'b1;
            end
        endcase
    end

    // Pipeline controls: a stall suppresses both the PC update and the flush.
    // The PC also stops in DRAIN so that no new instructions enter the pipeline.
    always_comb begin
        o_stall    = hz && !o_halt;
        o_pc_en    = !o_halt && !o_stall && (state != S_DRAIN);
        o_flush_if = i_jump && !o_halt && !o_stall;
    end

    // Drain counter: counts DRAIN cycles and sits at 0 in every other state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drain_cnt <= '0;
        end else if ((state == S_DRAIN) && !drain_last) begin
            drain_cnt <= drain_cnt + DW'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Unhalted-cycle counter. It saturates at all-ones. An accepted abort clears it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycle_count <= '0;
        end else if (abort_acc) begin
            o_cycle_count <= '0;
        end else if (!o_halt && (o_cycle_count != {NB_CNT{1'b1}})) begin
            o_cycle_count <= o_cycle_count + NB_CNT'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed plus randomized checks of pipeline_sequencer.
// The counter width is narrowed so that saturation can be reached quickly.
// Define HAZARD_DETECT_EN for both bench and RTL to exercise the hazard build.
module tb_pipeline_sequencer;

    localparam int CW    = 5;
    localparam int DRAIN = 4;
    localparam int CMAX  = (1 << CW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic [1:0]    i_cmd = 2'b00;
    logic          i_stop = 1'b0;
    logic [4:0]    i_id_rs = '0;
    logic [4:0]    i_id_rt = '0;
    logic          i_ex_memRead = 1'b0;
    logic [4:0]    i_ex_rt = '0;
    logic          i_jump = 1'b0;
    logic          o_cmd_ready, o_halt, o_stall, o_pc_en, o_flush_if, o_busy, o_done;
    logic [2:0]    o_state;
    logic [CW-1:0] o_cycle_count;

    always #5 clk = ~clk;

    pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .NB_CNT(CW)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready), .i_stop(i_stop), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_ex_memRead(i_ex_memRead), .i_ex_rt(i_ex_rt), .i_jump(i_jump),
        .o_halt(o_halt), .o_stall(o_stall), .o_pc_en(o_pc_en), .o_flush_if(o_flush_if),
        .o_busy(o_busy), .o_done(o_done), .o_state(o_state), .o_cycle_count(o_cycle_count)
    );

    // ---------------- reference model ----------------
    // Mode numbers are the documented state codes: 0 idle, 1 run, 2 step, 3 drain, 4 done.
    int checks = 0;
    int failures = 0;
    int m_mode = 0;
    int m_left = 0;   // drain cycles still to go
    int m_count = 0;  // unhalted cycles since reset/abort

    function automatic bit m_halted(int mode);
        return (mode == 0) || (mode == 4);
    endfunction

    function automatic bit m_hazard();
`ifdef HAZARD_DETECT_EN
        return i_ex_memRead && (i_ex_rt != 0) && ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        bit halt, stall;
        halt  = m_halted(m_mode);
        stall = m_hazard() && !halt;
        chk("state",   32'(o_state), 32'(m_mode));
        chk("halt",    32'(o_halt), 32'(halt));
        chk("busy",    32'(o_busy), 32'(m_mode >= 1 && m_mode <= 3));
        chk("done",    32'(o_done), 32'(m_mode == 4));
        chk("ready",   32'(o_cmd_ready), 32'(!(m_mode == 2 || m_mode == 3)));
        chk("stall",   32'(o_stall), 32'(stall));
        chk("pc_en",   32'(o_pc_en), 32'(!halt && !stall && m_mode != 3));
        chk("flush",   32'(o_flush_if), 32'(i_jump && !halt && !stall));
        chk("count",   32'(o_cycle_count), 32'(m_count));
    endtask

    // Advance the model by one rising edge, using the inputs now being driven.
    task automatic model_edge();
        bit acc;
        int nxt;
        acc = i_cmd_valid && !(m_mode == 2 || m_mode == 3);
        if (acc && i_cmd == 2'b11)       m_count = 0;
        else if (!m_halted(m_mode))      m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
        nxt = m_mode;
        case (m_mode)
            0: if (acc && i_cmd == 2'b01) nxt = 1;
               else if (acc && i_cmd == 2'b10) nxt = 2;
            1: if (acc && i_cmd == 2'b11) nxt = 0;
               else if (i_stop) begin nxt = 3; m_left = DRAIN; end
            2: if (i_stop) begin nxt = 3; m_left = DRAIN; end else nxt = 0;
            3: begin m_left--; if (m_left == 0) nxt = 4; end
            4: if (acc && i_cmd == 2'b11) nxt = 0;
            default: nxt = 0;
        endcase
        m_mode = nxt;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive inputs, check, take the rising edge, return at next fall.
    task automatic tick(input logic v, input logic [1:0] c, input logic stop);
        i_cmd_valid = v;
        i_cmd = c;
        i_stop = stop;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_hz(input logic mem, input logic [4:0] ex_rt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic jump);
        i_ex_memRead = mem; i_ex_rt = ex_rt; i_id_rs = rs; i_id_rt = rt; i_jump = jump;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset state, checked while reset is held.
        #1 check_all();
        @(negedge clk);
        i_rst_n = 1'b1;
        idle_ticks(2);

        // Run, HALT after 11 RUN cycles, drain, done with 15 counted cycles.
        tick(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 2'b00, 1'b0);
        tick(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < DRAIN; i++) begin
            #1 chk("drain_pc_en", 32'(o_pc_en), 0);
            tick(1'b1, 2'b01, 1'b0);      // offered but not accepted in DRAIN
        end
        #1 chk("done_flag", 32'(o_done), 1);
        chk("run_count15", 32'(o_cycle_count), 15);
        tick(1'b1, 2'b10, 1'b0);          // step accepted and ignored in DONE
        tick(1'b1, 2'b11, 1'b0);          // abort back to IDLE

        // Three single steps separated by two idle cycles.
        for (int s = 0; s < 3; s++) begin
            tick(1'b1, 2'b10, 1'b0);
            #1 chk("step_unhalted", 32'(o_halt), 0);
            tick(1'b0, 2'b00, 1'b0);
            #1 chk("step_back_idle", 32'(o_state), 0);
            tick(1'b0, 2'b00, 1'b0);
        end
        #1 chk("step_count3", 32'(o_cycle_count), 3);

        // Load-use hazard with a simultaneous jump, in RUN.
        tick(1'b1, 2'b01, 1'b0);
        set_hz(1'b1, 5'd5, 5'd5, 5'd9, 1'b1);
`ifdef HAZARD_DETECT_EN
        #1 chk("hz_stall", 32'(o_stall), 1);
        chk("hz_pc_en", 32'(o_pc_en), 0);
        chk("hz_flush", 32'(o_flush_if), 0);
`else
        #1 chk("nohz_stall", 32'(o_stall), 0);
        chk("nohz_pc_en", 32'(o_pc_en), 1);
`endif
        tick(1'b0, 2'b00, 1'b0);
        set_hz(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        #1 chk("r0_stall", 32'(o_stall), 0);
        chk("r0_flush", 32'(o_flush_if), 1);
        tick(1'b0, 2'b00, 1'b0);
        set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Abort and HALT together in RUN: abort wins, count clears.
        tick(1'b1, 2'b11, 1'b1);
        #1 chk("abort_idle", 32'(o_state), 0);
        chk("abort_count", 32'(o_cycle_count), 0);
        idle_ticks(1);

        // Asynchronous reset during the second DRAIN cycle.
        tick(1'b1, 2'b01, 1'b0);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b0);          // first DRAIN cycle
        i_jump = 1'b1;
        #2 i_rst_n = 1'b0;
        m_mode = 0; m_count = 0; m_left = 0;
        #1 chk("rst_state", 32'(o_state), 0);
        chk("rst_halt", 32'(o_halt), 1);
        chk("rst_pc_en", 32'(o_pc_en), 0);
        chk("rst_flush", 32'(o_flush_if), 0);
        check_all();
        @(negedge clk);
        i_rst_n = 1'b1;
        i_jump = 1'b0;
        idle_ticks(1);

        // Saturation of the narrowed counter.
        tick(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < CMAX + 8; i++) tick(1'b0, 2'b00, 1'b0);
        #1 chk("sat_count", 32'(o_cycle_count), CMAX);
        tick(1'b1, 2'b11, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_hz(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
